// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce timer family: FSM encoding and default timing.
package debounce_pkg;

    // Timer FSM states; the unused code 2'd3 is treated as illegal and recovers to CLEAR.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default timing: 50 MHz clock, 1 ms tick, 5/10/20/40 ms intervals.
    localparam int DEFAULT_PRESCALE = 50000;
    localparam int DEFAULT_CNT_W    = 8;
    localparam int DEFAULT_P0       = 5;
    localparam int DEFAULT_P1       = 10;
    localparam int DEFAULT_P2       = 20;
    localparam int DEFAULT_P3       = 40;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-PRESCALE counter with synchronous clear and enable.
// tick is high for the one enabled cycle in which the counter sits at PRESCALE-1.
module tick_prescaler
    import debounce_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("tick_prescaler: PRESCALE must be >= 2");
    end

    logic [W-1:0] count;

    // Prescaler counter: clear wins over enable; wraps at PRESCALE-1.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/debounce_timer.sv
// Interval timer for the debounce controller. Held cleared while timer_clr=1; after
// timer_clr falls it counts target ticks (target latched from period_sel on leaving
// CLEAR), then raises timer_done and holds it until the next clear.
module debounce_timer
    import debounce_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int P0       = DEFAULT_P0,
    parameter int P1       = DEFAULT_P1,
    parameter int P2       = DEFAULT_P2,
    parameter int P3       = DEFAULT_P3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_clr,
    input  logic [1:0]       period_sel,
    output logic             timer_done,
    output logic             tick,
    output logic [CNT_W-1:0] elapsed
);

    if (P0 < 1 || P1 < 1 || P2 < 1 || P3 < 1) begin : g_bad_period
        $error("debounce_timer: all intervals P0..P3 must be >= 1");
    end

    if (P0 >= (1 << CNT_W) || P1 >= (1 << CNT_W) ||
        P2 >= (1 << CNT_W) || P3 >= (1 << CNT_W)) begin : g_bad_width
        $error("debounce_timer: CNT_W too narrow for the largest interval");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] sel_target;
    logic             last_tick;
    logic             presc_clr;
    logic             presc_en;

    // Prescaler is zeroed in CLEAR (and on the clearing edge itself), frozen in DONE.
    assign presc_clr = (state == CLEAR) || timer_clr;
    assign presc_en  = (state == COUNT);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (tick)
    );

    // The final tick of the interval: the one that brings elapsed up to target.
    assign last_tick = tick && (elapsed == target - 1'b1);

    // Interval lookup for the current period_sel.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        sel_target = CNT_W'(P0);
        case (period_sel)
            2'd0:    sel_target = CNT_W'(P0);
            2'd1:    sel_target = CNT_W'(P1);
            2'd2:    sel_target = CNT_W'(P2);
            default: sel_target = CNT_W'(P3);
        endcase
    end

    // Next-state logic; a clear request beats the final tick.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (!timer_clr) state_next = COUNT;
            COUNT: begin
                if (timer_clr) begin
                    state_next = CLEAR;
                end else if (last_tick) begin
                    state_next = DONE;
                end
            end
            DONE:    if (timer_clr) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Target latch: period_sel is only looked at on the CLEAR->COUNT edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target <= CNT_W'(P0);
        end else if (state == CLEAR && !timer_clr) begin
            target <= sel_target;
        end
    end

    // Elapsed tick counter; reaches target on the final tick and stays there in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elapsed <= '0;
        end else if (state_next == CLEAR) begin
            elapsed <= '0;
        end else if (state == COUNT && tick) begin
            elapsed <= elapsed + 1'b1;
        end
    end

    // Registered done flag, high exactly while the FSM is in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_done <= 1'b0;
        end else begin
            timer_done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_debounce_timer.sv
// Self-checking bench for debounce_timer with a small timing configuration.
// An interval model (edge count since the last start) predicts every output each cycle.
module tb_debounce_timer;

    localparam int PS = 4;
    localparam int Q0 = 2;
    localparam int Q1 = 3;
    localparam int Q2 = 5;
    localparam int Q3 = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       timer_clr = 1'b1;
    logic [1:0] period_sel = 2'd0;
    logic       timer_done;
    logic       tick;
    logic [7:0] elapsed;

    int n_pass = 0;
    int n_total = 0;

    debounce_timer #(
        .PRESCALE (PS),
        .CNT_W    (8),
        .P0       (Q0),
        .P1       (Q1),
        .P2       (Q2),
        .P3       (Q3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .timer_clr  (timer_clr),
        .period_sel (period_sel),
        .timer_done (timer_done),
        .tick       (tick),
        .elapsed    (elapsed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int interval_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return Q0;
            2'd1:    return Q1;
            2'd2:    return Q2;
            default: return Q3;
        endcase
    endfunction

    // Reference model: running flag, edges since start, and latched interval in ticks.
    bit m_run = 1'b0;
    int m_n   = 0;
    int m_tgt = Q0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run <= 1'b0;
            m_n   <= 0;
            m_tgt <= Q0;
        end else if (timer_clr) begin
            m_run <= 1'b0;
            m_n   <= 0;
        end else if (!m_run) begin
            m_run <= 1'b1;
            m_n   <= 0;
            m_tgt <= interval_of(period_sel);
        end else begin
            m_n   <= m_n + 1;
        end
    end

    int ex_done;
    int ex_tick;
    int ex_el;

    // Every falling edge: outputs must match the interval arithmetic.
    always @(negedge clk) begin
        ex_done = (m_run && m_n >= m_tgt * PS) ? 1 : 0;
        ex_tick = (m_run && ex_done == 0 && (m_n % PS) == PS - 1) ? 1 : 0;
        ex_el   = m_run ? ((m_n / PS < m_tgt) ? m_n / PS : m_tgt) : 0;
        check("model_done", 32'(timer_done), ex_done);
        check("model_tick", 32'(tick), ex_tick);
        check("model_elapsed", 32'(elapsed), ex_el);
    end

    // Advance n clock edges; inputs then change 2 time units after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Assert reset between edges, confirm outputs drop at once, release mid-cycle.
    task automatic mid_reset(input string tag);
        #1;
        reset = 1'b0;
        #1;
        check({tag, "_done0"}, 32'(timer_done), 0);
        check({tag, "_tick0"}, 32'(tick), 0);
        check({tag, "_elapsed0"}, 32'(elapsed), 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #2;
    endtask

    bit stable;
    bit raw;
    int rise_at;
    int fell;

    initial begin
        // Reset state.
        step(2);
        check("reset_done", 32'(timer_done), 0);
        check("reset_tick", 32'(tick), 0);
        check("reset_elapsed", 32'(elapsed), 0);
        #1;
        reset = 1'b1;
        step(2);

        // 1: P0 interval, done exactly 8 edges after start, then held.
        period_sel = 2'd0;
        timer_clr  = 1'b0;
        step(1);
        step(7);
        check("t1_done_early", 32'(timer_done), 0);
        step(1);
        check("t1_done_rise", 32'(timer_done), 1);
        check("t1_elapsed", 32'(elapsed), 2);
        step(20);
        check("t1_done_hold", 32'(timer_done), 1);
        check("t1_elapsed_sat", 32'(elapsed), 2);
        timer_clr = 1'b1;
        step(1);
        check("t1_cleared", 32'(timer_done), 0);
        step(1);

        // 2: P3 latched at start; later period_sel change ignored.
        period_sel = 2'd3;
        timer_clr  = 1'b0;
        step(1);
        step(5);
        period_sel = 2'd0;
        step(26);
        check("t2_done_early", 32'(timer_done), 0);
        step(1);
        check("t2_done_rise", 32'(timer_done), 1);
        check("t2_elapsed", 32'(elapsed), 8);
        timer_clr = 1'b1;
        step(2);

        // 3: one-cycle clear pulse restarts the P1 interval.
        period_sel = 2'd1;
        timer_clr  = 1'b0;
        step(1);
        step(5);
        check("t3_elapsed_run", 32'(elapsed), 1);
        timer_clr = 1'b1;
        step(1);
        check("t3_elapsed_zero", 32'(elapsed), 0);
        timer_clr = 1'b0;
        step(1);
        step(5);
        check("t3_no_done_old_e0", 32'(timer_done), 0);
        step(6);
        check("t3_done_early", 32'(timer_done), 0);
        step(1);
        check("t3_done_rise", 32'(timer_done), 1);
        timer_clr = 1'b1;
        step(2);

        // 4: clear sampled on the final-tick edge wins; no done.
        period_sel = 2'd0;
        timer_clr  = 1'b0;
        step(1);
        step(7);
        check("t4_tick_last", 32'(tick), 1);
        timer_clr = 1'b1;
        step(1);
        check("t4_done", 32'(timer_done), 0);
        check("t4_elapsed", 32'(elapsed), 0);
        step(3);
        check("t4_done_later", 32'(timer_done), 0);

        // 5: async reset mid-COUNT (while tick is high) and mid-DONE.
        timer_clr = 1'b0;
        step(1);
        step(3);
        check("t5_tick_before", 32'(tick), 1);
        mid_reset("t5_count");
        step(7);
        check("t5_restart_early", 32'(timer_done), 0);
        step(1);
        check("t5_restart_rise", 32'(timer_done), 1);
        step(3);
        mid_reset("t5_done");
        step(7);
        check("t5_redone_early", 32'(timer_done), 0);
        step(1);
        check("t5_redone_rise", 32'(timer_done), 1);

        // 6: closed loop with a minimal debounce controller.
        timer_clr = 1'b1;
        period_sel = 2'd0;
        step(2);
        stable  = 1'b0;
        raw     = 1'b0;
        rise_at = -1;
        for (int i = 0; i < 30; i++) begin
            if (timer_done && stable != raw) begin
                stable = raw;
                if (rise_at < 0) rise_at = i;
            end
            raw       = (i == 1) ? 1'b0 : 1'b1;
            timer_clr = (raw == stable);
            step(1);
        end
        check("t6_rise_cycle", rise_at, 11);
        check("t6_stable_high", 32'(stable), 1);
        fell = 0;
        for (int i = 0; i < 30; i++) begin
            if (timer_done && stable != raw) begin
                stable = raw;
                fell   = 1;
            end
            raw       = (i >= 2 && i < 9) ? 1'b0 : 1'b1;
            timer_clr = (raw == stable);
            step(1);
        end
        check("t6_glitch_rejected", fell, 0);
        check("t6_stable_kept", 32'(stable), 1);

        // Randomized clear/run segments with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            timer_clr  = 1'b1;
            period_sel = 2'($urandom_range(0, 3));
            step($urandom_range(1, 3));
            timer_clr = 1'b0;
            repeat ($urandom_range(1, 45)) begin
                if ($urandom_range(0, 3) == 0) period_sel = 2'($urandom_range(0, 3));
                step(1);
            end
            if (seg % 15 == 7) mid_reset("rnd");
        end

        timer_clr = 1'b1;
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
